// File: rtl/sxsp_core.sv
// Multicycle accumulator CPU with parametrised data/address width and a
// mem_rdy wait-state handshake on a shared tristate memory bus.
module sxsp_core #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] add,
    inout  wire  [DATA_W-1:0] dat,
    output logic              rd,
    output logic              wrt,
    input  logic              mem_rdy,
    output logic              halted,
    output logic [DATA_W-1:0] acc_dbg
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_ARG,
        S_MRD,
        S_MWR,
        S_EXEC,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_LD   = 4'h2;
    localparam logic [3:0] OP_ST   = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_JMP  = 4'h6;
    localparam logic [3:0] OP_JZ   = 4'h7;
    localparam logic [3:0] OP_JC   = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t              state_reg;
    logic [ADDR_W-1:0]   pc_reg;
    logic [ADDR_W-1:0]   ar_reg;
    logic [3:0]          ir_reg;
    logic [DATA_W-1:0]   dr_reg;
    logic [DATA_W-1:0]   acc_reg;
    logic                z_reg;
    logic                c_reg;
    logic [ADDR_W-1:0]   add_hold_reg;
    logic [ADDR_W-1:0]   add_next;
    logic [DATA_W:0]     sum_ext;
    logic [DATA_W:0]     diff_ext;

    assign sum_ext  = {1'b0, acc_reg} + {1'b0, dr_reg};
    assign diff_ext = {1'b0, acc_reg} - {1'b0, dr_reg};

    // Address follows the active request; idle states keep the last driven value.
    always_comb begin
        add_next = add_hold_reg;
        case (state_reg)
            S_FETCH, S_ARG: add_next = pc_reg;
            S_MRD, S_MWR:   add_next = ar_reg;
            default:        add_next = add_hold_reg;
        endcase
    end

    // Bus strobes are gated by reset so an in-flight access drops the moment reset rises.
    assign add     = reset ? '0 : add_next;
    assign rd      = !reset && (state_reg == S_FETCH || state_reg == S_ARG || state_reg == S_MRD);
    assign wrt     = !reset && (state_reg == S_MWR);
    assign dat     = wrt ? acc_reg : 'z;
    assign halted  = (state_reg == S_HALT);
    assign acc_dbg = acc_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= S_FETCH;
            pc_reg       <= RESET_PC;
            ar_reg       <= '0;
            ir_reg       <= '0;
            dr_reg       <= '0;
            acc_reg      <= '0;
            z_reg        <= 1'b0;
            c_reg        <= 1'b0;
            add_hold_reg <= '0;
        end else begin
            add_hold_reg <= add_next;
            case (state_reg)
                S_FETCH: begin
                    if (mem_rdy) begin
                        ir_reg    <= dat[3:0];
                        pc_reg    <= pc_reg + 1'b1;
                        state_reg <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    case (ir_reg)
                        OP_LDI, OP_LD, OP_ST, OP_ADD, OP_SUB,
                        OP_JMP, OP_JZ, OP_JC: state_reg <= S_ARG;
                        OP_HALT:              state_reg <= S_HALT;
                        default:              state_reg <= S_FETCH;
                    endcase
                end
                S_ARG: begin
                    if (mem_rdy) begin
                        dr_reg <= dat;
                        ar_reg <= dat[ADDR_W-1:0];
                        pc_reg <= pc_reg + 1'b1;
                        case (ir_reg)
                            OP_LD, OP_ADD, OP_SUB: state_reg <= S_MRD;
                            OP_ST:                 state_reg <= S_MWR;
                            default:               state_reg <= S_EXEC;
                        endcase
                    end
                end
                S_MRD: begin
                    if (mem_rdy) begin
                        dr_reg    <= dat;
                        state_reg <= S_EXEC;
                    end
                end
                S_MWR: begin
                    if (mem_rdy) begin
                        state_reg <= S_FETCH;
                    end
                end
                S_EXEC: begin
                    case (ir_reg)
                        OP_LDI, OP_LD: begin
                            acc_reg <= dr_reg;
                            z_reg   <= (dr_reg == '0);
                        end
                        OP_ADD: begin
                            acc_reg <= sum_ext[DATA_W-1:0];
                            c_reg   <= sum_ext[DATA_W];
                            z_reg   <= (sum_ext[DATA_W-1:0] == '0);
                        end
                        OP_SUB: begin
                            acc_reg <= diff_ext[DATA_W-1:0];
                            c_reg   <= diff_ext[DATA_W];
                            z_reg   <= (diff_ext[DATA_W-1:0] == '0);
                        end
                        OP_JMP: pc_reg <= ar_reg;
                        OP_JZ:  if (z_reg) pc_reg <= ar_reg;
                        OP_JC:  if (c_reg) pc_reg <= ar_reg;
                        default: ;
                    endcase
                    state_reg <= S_FETCH;
                end
                S_HALT:  state_reg <= S_HALT;
                default: state_reg <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_sxsp_core.sv
// Directed bench for sxsp_core: program table run to HALT on a wait-state
// memory model, plus reset-during-write, PC wrap and halted-bus sequences.
module tb_sxsp_core;

    logic       clk;
    logic       reset;
    logic       mem_rdy;
    logic       mem_rdy2;
    wire  [7:0] dat;
    wire  [7:0] dat2;
    logic [7:0] add, add2, acc_dbg, acc_dbg2;
    logic       rd, wrt, halted, rd2, wrt2, halted2;

    logic [7:0] mem  [256];
    logic [7:0] mem2 [256];

    sxsp_core #(.DATA_W(8), .ADDR_W(8), .RESET_PC(8'h00)) u_dut (
        .clk(clk), .reset(reset), .add(add), .dat(dat), .rd(rd), .wrt(wrt),
        .mem_rdy(mem_rdy), .halted(halted), .acc_dbg(acc_dbg)
    );

    sxsp_core #(.DATA_W(8), .ADDR_W(8), .RESET_PC(8'hFE)) u_dut2 (
        .clk(clk), .reset(reset), .add(add2), .dat(dat2), .rd(rd2), .wrt(wrt2),
        .mem_rdy(mem_rdy2), .halted(halted2), .acc_dbg(acc_dbg2)
    );

    // Memory answers reads combinationally; writes are committed by bus_update.
    assign dat  = (rd && !wrt) ? mem[add] : 'z;
    assign dat2 = (rd2 && !wrt2) ? mem2[add2] : 'z;

    always #5 clk = ~clk;

    typedef struct {
        logic [95:0]      name;
        logic [63:0]      prog;
        logic [2:0][15:0] pokes;
        int               wait_n;
        int               exp_edges;
        logic [7:0]       exp_acc;
        logic             exp_z;
        logic             exp_c;
        logic [7:0]       exp_pc;
        logic [7:0]       chk_addr;
        logic [7:0]       chk_val;
    } vec_t;

    localparam int NVEC = 9;
    vec_t vecs[NVEC];

    int checks;
    int failures;
    int edges;
    int wait_n;
    int stall_cnt;
    int wr_count;
    int halt_bus;
    logic       prev_stalled;
    logic [7:0] prev_add;
    logic       prev_rd, prev_wrt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Called away from the clock edge: stability checks, then the wait-state model.
    task automatic bus_update();
        if (prev_stalled) begin
            chk("stall_add_stable", {24'h0, add}, {24'h0, prev_add});
            chk("stall_req_stable", {30'h0, rd, wrt}, {30'h0, prev_rd, prev_wrt});
        end
        chk("rd_wrt_exclusive", {31'h0, rd && wrt}, 32'h0);
        if (rd || wrt) begin
            if (stall_cnt >= wait_n) begin
                mem_rdy   = 1'b1;
                stall_cnt = 0;
            end else begin
                mem_rdy   = 1'b0;
                stall_cnt++;
            end
        end else begin
            mem_rdy   = 1'b0;
            stall_cnt = 0;
        end
        if (wrt && mem_rdy) begin
            mem[add] = dat;
            wr_count++;
        end
        if (halted && (rd || wrt)) halt_bus++;
        prev_stalled = (rd || wrt) && !mem_rdy;
        prev_add     = add;
        prev_rd      = rd;
        prev_wrt     = wrt;
    endtask

    task automatic tick();
        @(posedge clk);
        edges++;
        @(negedge clk);
        bus_update();
    endtask

    task automatic release_reset();
        reset = 1'b0;
        #1;
        edges        = 0;
        wr_count     = 0;
        halt_bus     = 0;
        stall_cnt    = 0;
        prev_stalled = 1'b0;
        bus_update();
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        mem_rdy      = 1'b0;
        prev_stalled = 1'b0;
        @(posedge clk);
        @(negedge clk);
        release_reset();
    endtask

    task automatic run_to_halt(input int limit);
        while (!halted && edges < limit) tick();
    endtask

    task automatic load_vec(input int i);
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        for (int k = 0; k < 8; k++) mem[k] = vecs[i].prog[63-8*k -: 8];
        for (int p = 0; p < 3; p++) mem[vecs[i].pokes[p][15:8]] = vecs[i].pokes[p][7:0];
        wait_n = vecs[i].wait_n;
    endtask

    initial begin
        clk = 1'b0; reset = 1'b1; mem_rdy = 1'b0; mem_rdy2 = 1'b1;
        checks = 0; failures = 0; edges = 0; wait_n = 0; stall_cnt = 0;
        wr_count = 0; halt_bus = 0; prev_stalled = 1'b0;
        prev_add = 8'h00; prev_rd = 1'b0; prev_wrt = 1'b0;
        for (int a = 0; a < 256; a++) begin mem[a] = 8'h00; mem2[a] = 8'h00; end

        //         name          program bytes 0..7          pokes {addr,val}             wait edges acc   z     c     pc     chk addr/val
        vecs[0] = '{"ldi_add_st",  64'h01_05_04_10_03_11_0F_00, {16'h10FB, 16'h115A, 16'hFF00}, 0, 15, 8'h00, 1'b1, 1'b1, 8'h07, 8'h11, 8'h00};
        vecs[1] = '{"ldi_add_st_w",64'h01_05_04_10_03_11_0F_00, {16'h10FB, 16'h115A, 16'hFF00}, 3, 42, 8'h00, 1'b1, 1'b1, 8'h07, 8'h11, 8'h00};
        vecs[2] = '{"sub_jc",      64'h01_03_05_20_08_08_01_77, {16'h080F, 16'h2004, 16'hFF00}, 0, 15, 8'hFF, 1'b0, 1'b1, 8'h09, 8'h20, 8'h04};
        vecs[3] = '{"sub_jc_w1",   64'h01_03_05_20_08_08_01_77, {16'h080F, 16'h2004, 16'hFF00}, 1, 23, 8'hFF, 1'b0, 1'b1, 8'h09, 8'h20, 8'h04};
        vecs[4] = '{"undef_nop",   64'h0A_0F_00_00_00_00_00_00, {16'hFF00, 16'hFF00, 16'hFF00}, 0,  4, 8'h00, 1'b0, 1'b0, 8'h02, 8'hFF, 8'h00};
        vecs[5] = '{"add_jz_not",  64'h01_02_04_10_07_20_0F_00, {16'h1003, 16'h200F, 16'hFF00}, 0, 15, 8'h05, 1'b0, 1'b0, 8'h07, 8'h10, 8'h03};
        vecs[6] = '{"ld_add_jz",   64'h02_10_04_11_07_08_01_77, {16'h080F, 16'h1080, 16'h1180}, 0, 16, 8'h00, 1'b1, 1'b1, 8'h09, 8'h11, 8'h80};
        vecs[7] = '{"jmp_hibits",  64'h01_AA_36_06_01_BB_0F_00, {16'hFF00, 16'hFF00, 16'hFF00}, 0, 10, 8'hAA, 1'b0, 1'b0, 8'h07, 8'hFF, 8'h00};
        vecs[8] = '{"sub_zero",    64'h01_44_05_10_0F_00_00_00, {16'h1044, 16'hFF00, 16'hFF00}, 0, 11, 8'h00, 1'b1, 1'b0, 8'h05, 8'h10, 8'h44};

        // Reset state while reset is held.
        #1;
        chk("reset_rd", {31'h0, rd}, 32'h0);
        chk("reset_wrt", {31'h0, wrt}, 32'h0);
        chk("reset_add", {24'h0, add}, 32'h0);
        chk("reset_halted", {31'h0, halted}, 32'h0);
        chk("reset_acc", {24'h0, acc_dbg}, 32'h0);
        chk("reset_add2", {24'h0, add2}, 32'h0);
        chk("reset_pc2", {24'h0, u_dut2.pc_reg}, 32'hFE);

        // RESET_PC=FE: JMP 04 straddling the PC wrap.
        mem2[8'hFE] = 8'h06; mem2[8'hFF] = 8'h04; mem2[8'h04] = 8'h0F;
        do_reset();
        chk("wrap_first_add", {24'h0, add2}, 32'hFE);
        chk("wrap_first_rd", {31'h0, rd2}, 32'h1);
        tick(); tick();
        chk("wrap_arg_add", {24'h0, add2}, 32'hFF);
        tick();
        chk("wrap_pc_after_arg", {24'h0, u_dut2.pc_reg}, 32'h00);
        tick();
        chk("wrap_pc_after_exec", {24'h0, u_dut2.pc_reg}, 32'h04);
        while (!halted2 && edges < 50) tick();
        chk("wrap_halt_edges", edges, 6);
        chk("wrap_halt_pc", {24'h0, u_dut2.pc_reg}, 32'h05);
        $display("seq pc_wrap edges=%0d pc=%0h halted=%0b", edges, u_dut2.pc_reg, halted2);

        for (int i = 0; i < NVEC; i++) begin
            load_vec(i);
            do_reset();
            run_to_halt(400);
            chk("halted", {31'h0, halted}, 32'h1);
            chk("halt_edges", edges, vecs[i].exp_edges);
            chk("acc", {24'h0, acc_dbg}, {24'h0, vecs[i].exp_acc});
            chk("z_flag", {31'h0, u_dut.z_reg}, {31'h0, vecs[i].exp_z});
            chk("c_flag", {31'h0, u_dut.c_reg}, {31'h0, vecs[i].exp_c});
            chk("pc", {24'h0, u_dut.pc_reg}, {24'h0, vecs[i].exp_pc});
            chk("mem_word", {24'h0, mem[vecs[i].chk_addr]}, {24'h0, vecs[i].chk_val});
            $display("vec %0s edges=%0d acc=%0h z=%0b c=%0b pc=%0h", vecs[i].name, edges,
                     acc_dbg, u_dut.z_reg, u_dut.c_reg, u_dut.pc_reg);
        end

        // Undefined opcode then HALT: bus must stay silent while halted.
        load_vec(4);
        do_reset();
        run_to_halt(50);
        for (int k = 0; k < 20; k++) tick();
        chk("halt_sticky", {31'h0, halted}, 32'h1);
        chk("halt_bus_quiet", halt_bus, 0);
        $display("seq halt_quiet halted=%0b bus_cycles=%0d", halted, halt_bus);

        // Reset asserted while a stalled write is pending.
        load_vec(1);
        do_reset();
        while (!wrt && edges < 100) tick();
        chk("mwr_reached", {31'h0, wrt}, 32'h1);
        tick();
        reset   = 1'b1;
        mem_rdy = 1'b0;
        #1;
        chk("rst_mwr_wrt", {31'h0, wrt}, 32'h0);
        chk("rst_mwr_rd", {31'h0, rd}, 32'h0);
        chk("rst_mwr_add", {24'h0, add}, 32'h0);
        chk("rst_mwr_acc", {24'h0, acc_dbg}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_mwr_no_write", {24'h0, mem[8'h11]}, 32'h5A);
        release_reset();
        chk("rst_refetch_rd", {31'h0, rd}, 32'h1);
        chk("rst_refetch_add", {24'h0, add}, 32'h0);
        run_to_halt(400);
        chk("rst_rerun_edges", edges, 42);
        chk("rst_rerun_mem", {24'h0, mem[8'h11]}, 32'h00);
        chk("rst_rerun_writes", wr_count, 1);
        $display("seq reset_mid_write edges=%0d m11=%0h writes=%0d", edges, mem[8'h11], wr_count);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
